// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back path.
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } lookup_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] rd);
        logic [NUM_REGS-1:0] v;
        v     = {NUM_REGS{1'b0}};
        v[rd] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/regfile_wb_driver_if.sv
// Result-source handshake bundle: load/store path (mem_*) and ALU path (alu_*).
interface regfile_wb_driver_if;
    import regfile_pkg::*;

    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;

    modport master (
        output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
        input  mem_ready, alu_ready
    );

    modport slave (
        input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
        output mem_ready, alu_ready
    );
endinterface

// File: rtl/regfile_wb_driver_wb_fifo.sv
// Write queue: dual push (a older than b), single pop, all entries exported for lookup.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      i_push_a,
    input  wb_entry_t                                 i_entry_a,
    input  logic                                      i_push_b,
    input  wb_entry_t                                 i_entry_b,
    input  logic                                      i_pop,
    output wb_entry_t                                 o_head,
    output logic [$clog2(DEPTH):0]                    o_count,
    output wb_entry_t [DEPTH-1:0]                     o_entries,
    output logic [DEPTH-1:0]                          o_valid,
    output logic [DEPTH-1:0][$clog2(DEPTH)-1:0]       o_age
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;

    logic [PW-1:0]         w_wr_next;
    logic [1:0]            w_push_cnt;
    logic                  w_pop;

    assign w_wr_next  = r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
    assign w_push_cnt = {1'b0, i_push_a} + {1'b0, i_push_b};
    assign w_pop      = i_pop && (r_count != {(PW+1){1'b0}});

    // Storage, pointer and occupancy update; a lone push always lands at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else begin
            if (i_push_a) begin
                r_mem[r_wr_ptr] <= i_entry_a;
                if (i_push_b) begin
                    r_mem[w_wr_next] <= i_entry_b;
                end
            end else if (i_push_b) begin
                r_mem[r_wr_ptr] <= i_entry_b;
            end
            r_wr_ptr <= r_wr_ptr + PW'(w_push_cnt);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            r_count <= r_count + (PW+1)'(w_push_cnt) - (PW+1)'(w_pop);
        end
    end

    // Age is distance from the head: 0 = oldest, larger = younger.
    always_comb begin
        logic [PW-1:0] v_age;
        o_age   = '0;
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_age      = PW'(i) - r_rd_ptr;
            o_age[i]   = v_age;
            o_valid[i] = ({1'b0, v_age} < r_count);
        end
    end

    assign o_entries = r_mem;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
endmodule

// File: rtl/regfile_wb_driver.sv
// Sole write-port driver of the 32x32 register file: merges ALU/load results,
// queues them in order, issues one write per cycle and exposes two bypass lookups.
module regfile_wb_driver
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_wb_driver_if.slave       wb,
    output logic [NUM_REGS-1:0]      Dselect,
    output logic [XLEN-1:0]          dbus,
    input  logic [REG_AW-1:0]        qa_rd,
    output logic                     qa_hit,
    output logic [XLEN-1:0]          qa_data,
    input  logic [REG_AW-1:0]        qb_rd,
    output logic                     qb_hit,
    output logic [XLEN-1:0]          qb_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t                 w_head;
    wb_entry_t [DEPTH-1:0]     w_entries;
    logic [DEPTH-1:0]          w_valid;
    logic [DEPTH-1:0][PW-1:0]  w_age;
    logic [CW-1:0]             w_count;
    logic [CW-1:0]             w_free;
    logic                      w_push_a;
    logic                      w_push_b;
    logic                      w_issue;
    lookup_t                   w_qa;
    lookup_t                   w_qb;

    assign w_free  = CW'(DEPTH) - w_count;
    assign w_issue = (w_count != {CW{1'b0}});

    // When both sources are valid the ALU needs room behind the load entry.
    always_comb begin
        wb.mem_ready = (w_free >= CW'(1));
        if (wb.mem_valid) begin
            wb.alu_ready = (w_free >= CW'(2));
        end else begin
            wb.alu_ready = (w_free >= CW'(1));
        end
    end

    assign w_push_a = wb.mem_valid && wb.mem_ready && (wb.mem_rd != {REG_AW{1'b0}});
    assign w_push_b = wb.alu_valid && wb.alu_ready && (wb.alu_rd != {REG_AW{1'b0}});

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push_a  (w_push_a),
        .i_entry_a ({wb.mem_rd, wb.mem_data}),
        .i_push_b  (w_push_b),
        .i_entry_b ({wb.alu_rd, wb.alu_data}),
        .i_pop     (w_issue),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_entries (w_entries),
        .o_valid   (w_valid),
        .o_age     (w_age)
    );

    // Issue register: drives the register file, which captures on the following negedge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Dselect <= {NUM_REGS{1'b0}};
            dbus    <= {XLEN{1'b0}};
        end else if (w_issue) begin
            Dselect <= reg_onehot(w_head.rd);
            dbus    <= w_head.data;
        end else begin
            Dselect <= {NUM_REGS{1'b0}};
        end
    end

    function automatic lookup_t lookup(
        input logic [REG_AW-1:0]      q_rd,
        input logic [NUM_REGS-1:0]    dsel,
        input logic [XLEN-1:0]        dval,
        input wb_entry_t [DEPTH-1:0]  ent,
        input logic [DEPTH-1:0]       vld,
        input logic [DEPTH-1:0][PW-1:0] age
    );
        lookup_t       r;
        logic          found_q;
        logic [PW-1:0] best;
        r       = '0;
        found_q = 1'b0;
        best    = {PW{1'b0}};
        if (q_rd != {REG_AW{1'b0}}) begin
            // In-flight write is the oldest candidate; any queued match overrides it.
            if (dsel[q_rd]) begin
                r.hit  = 1'b1;
                r.data = dval;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && (ent[i].rd == q_rd) && (!found_q || (age[i] > best))) begin
                    found_q = 1'b1;
                    best    = age[i];
                    r.hit   = 1'b1;
                    r.data  = ent[i].data;
                end
            end
        end
        return r;
    endfunction

    assign w_qa    = lookup(qa_rd, Dselect, dbus, w_entries, w_valid, w_age);
    assign w_qb    = lookup(qb_rd, Dselect, dbus, w_entries, w_valid, w_age);
    assign qa_hit  = w_qa.hit;
    assign qa_data = w_qa.data;
    assign qb_hit  = w_qb.hit;
    assign qb_data = w_qb.data;
    assign count   = w_count;
endmodule

// File: tb/tb_regfile_wb_driver.sv
// Scoreboard bench for regfile_wb_driver: accepted writes are queued as expected
// issues and a negedge monitor checks every driven write, occupancy and the regfile.
module tb_regfile_wb_driver;
    import regfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   Dselect;
    logic [31:0]   dbus;
    logic [4:0]    qa_rd = 5'd0;
    logic [4:0]    qb_rd = 5'd0;
    logic          qa_hit, qb_hit;
    logic [31:0]   qa_data, qb_data;
    logic [CW-1:0] count;

    regfile_wb_driver_if wbif();

    regfile_wb_driver #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb      (wbif),
        .Dselect (Dselect),
        .dbus    (dbus),
        .qa_rd   (qa_rd),
        .qa_hit  (qa_hit),
        .qa_data (qa_data),
        .qb_rd   (qb_rd),
        .qb_hit  (qb_hit),
        .qb_data (qb_data),
        .count   (count)
    );

    always #5 clk = ~clk;

    wb_entry_t   expq[$];
    logic [31:0] regs[32];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: capture writes into the regfile model and pop/compare each issued write.
    always @(negedge clk) begin
        wb_entry_t e;
        if (rst_n) begin
            for (int i = 0; i < 32; i++) begin
                if (Dselect[i]) regs[i] = dbus;
            end
            if (Dselect != 32'd0) begin
                if (expq.size() == 0) begin
                    check("spurious_issue", Dselect, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("dselect", Dselect, 32'd1 << e.rd);
                    check("dbus", dbus, e.data);
                end
            end
            check("count", 32'(count), 32'(expq.size()));
        end
    end

    // One cycle of source stimulus; readiness comes from the bench's own occupancy.
    task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad);
        int   free;
        logic emr, ear;
        wbif.mem_valid = mv;  wbif.mem_rd = mrd;  wbif.mem_data = md;
        wbif.alu_valid = av;  wbif.alu_rd = ard;  wbif.alu_data = ad;
        @(negedge clk); #1;
        free = DEPTH - expq.size();
        emr  = (free >= 1);
        ear  = mv ? (free >= 2) : (free >= 1);
        check("mem_ready", {31'd0, wbif.mem_ready}, {31'd0, emr});
        check("alu_ready", {31'd0, wbif.alu_ready}, {31'd0, ear});
        if (mv && emr && mrd != 5'd0) expq.push_back('{rd: mrd, data: md});
        if (av && ear && ard != 5'd0) expq.push_back('{rd: ard, data: ad});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        wbif.mem_valid = 1'b0; wbif.mem_rd = 5'd0; wbif.mem_data = 32'd0;
        wbif.alu_valid = 1'b0; wbif.alu_rd = 5'd0; wbif.alu_data = 32'd0;
        #12;
        check("reset_dselect", Dselect, 32'd0);
        check("reset_dbus", dbus, 32'd0);
        check("reset_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single ALU write
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        idle(); idle();
        check("r5_written", regs[5], 32'hDEADBEEF);

        // 2: same-cycle writes to r3, alu is younger
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        qa_rd = 5'd3; #1;
        check("qa_hit_r3", {31'd0, qa_hit}, 32'd1);
        check("qa_data_r3", qa_data, 32'h22);
        idle();
        check("qa_data_r3_inflight_old", qa_data, 32'h22);
        idle(); idle();
        check("r3_final", regs[3], 32'h22);

        // 3: rd=0 transfer is dropped
        qa_rd = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("qa_hit_r0", {31'd0, qa_hit}, 32'd0);
        idle();

        // 4: both sources valid for 8 cycles
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 5'(8 + c), 32'h100 + 32'(c), 1'b1, 5'(16 + c), 32'h200 + 32'(c));
        end
        for (int c = 0; c < 5; c++) idle();

        // 5: reset with entries pending
        drive(1'b1, 5'd20, 32'hA0, 1'b1, 5'd21, 32'hA1);
        drive(1'b1, 5'd22, 32'hA2, 1'b1, 5'd23, 32'hA3);
        wbif.mem_valid = 1'b0; wbif.alu_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midreset_dselect", Dselect, 32'd0);
        check("midreset_count", 32'(count), 32'd0);
        expq.delete();
        #1 rst_n = 1'b1;
        idle(); idle(); idle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        idle(); idle();
        check("r7_after_reset", regs[7], 32'h77);

        // 6: back-to-back single writes, pointers wrap
        for (int r = 1; r <= 10; r++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 32'(r * 16));
        end
        qb_rd = 5'd10; #1;
        check("qb_hit_r10_queued", {31'd0, qb_hit}, 32'd1);
        check("qb_data_r10_queued", qb_data, 32'd160);
        idle();
        check("qb_hit_r10_inflight", {31'd0, qb_hit}, 32'd1);
        check("qb_data_r10_inflight", qb_data, 32'd160);
        idle();
        check("qb_hit_r10_done", {31'd0, qb_hit}, 32'd0);
        check("qb_data_r10_done", qb_data, 32'd0);
        qb_rd = 5'd0;
        idle();

        check("r10_written", regs[10], 32'd160);
        check("r0_never_written", regs[0], 32'd0);
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
